muldiv_unit: RTL and testbench

- Iterative, parametrised successor to the single-cycle ALU decode path. It decodes RV32M R-type operations (ALUOp=2'b10, Funct7=7'b0000001) and executes them over multiple cycles.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a radix-2 shift-add multiplier and a restoring divider.
- Sits beside the ALU in the execute stage. It drives a stall request to the pipeline while computing and returns a registered result with a valid strobe.

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// operating on magnitudes, with the sign fix-up applied as the result is registered.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 accept;
  logic                 is_div, is_rem, signed_a, signed_b, sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 div_zero, div_ovf, fast;
  logic [WIDTH-1:0]     fast_res;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, final_res;

  assign accept = in_valid & (state_q == IDLE) & (ALUOp == 2'b10) &
                  (Funct7 == 7'b0000001) & ~flush;

  // Operand decode at acceptance: signedness, magnitudes and the fast-path cases.
  always_comb begin
    is_div   = Funct3[2];
    is_rem   = Funct3[2] & Funct3[1];
    signed_a = (Funct3 == 3'b000) | (Funct3 == 3'b001) | (Funct3 == 3'b010) |
               (Funct3 == 3'b100) | (Funct3 == 3'b110);
    signed_b = (Funct3 == 3'b000) | (Funct3 == 3'b001) |
               (Funct3 == 3'b100) | (Funct3 == 3'b110);
    sign_a   = signed_a & SrcA[WIDTH-1];
    sign_b   = signed_b & SrcB[WIDTH-1];
    mag_a    = sign_a ? -SrcA : SrcA;
    mag_b    = sign_b ? -SrcB : SrcB;
    div_zero = is_div & (SrcB == '0);
    div_ovf  = is_div & ~Funct3[0] & (SrcA == MIN_VAL) & (SrcB == '1);
    fast     = div_zero | div_ovf;
    fast_res = '0;
    if (div_zero) begin
      fast_res = is_rem ? SrcA : '1;
    end else if (div_ovf) begin
      fast_res = is_rem ? '0 : MIN_VAL;
    end
  end

  // One iteration step; the accumulator holds {hi, lo} for multiply and {rem, quo} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) begin
        step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod_fix = neg_q ? -step_acc : step_acc;
    quo_fix  = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    rem_fix  = neg_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:          final_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010,
      3'b011:          final_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:  final_res = quo_fix;
      default:         final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = Funct3;
          neg_d = is_rem ? sign_a : (sign_a ^ sign_b);
          acc_d = {{WIDTH{1'b0}}, mag_a};
          b_d   = mag_b;
          cnt_d = CNT_W'(WIDTH - 1);
          if (fast) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          if (cnt_q == '0) begin
            result_d = final_res;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC) | ((state_q == IDLE) & accept);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32) with hand-computed expectations.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        flush;
  logic        in_ready, busy, out_valid;
  logic [31:0] Result;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .flush(flush), .in_ready(in_ready),
    .busy(busy), .out_valid(out_valid), .Result(Result)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Presents one M op for a single cycle; returns at the negedge right after the accept edge.
  task automatic startOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int busy_at_accept);
    @(negedge clk);
    in_valid = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b;
    #1 busy_at_accept = int'(busy);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Runs one op to completion; lat counts clock edges from the accept cycle to out_valid.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busy_cycles, output logic [31:0] res);
    int b0;
    startOp(f3, a, b, b0);
    busy_cycles = b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    res = Result;
  endtask

  initial begin
    int lat, bc, seen;
    logic [31:0] res;
    reset = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; Funct7 = 7'b0; Funct3 = 3'b0;
    SrcA = '0; SrcB = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset Result", Result, 32'h0);

    applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, lat, bc, res);
    checkOutput("MUL result", res, 32'hFFFFFFEB);
    checkOutput("MUL latency", 32'(lat), 32'd33);
    checkOutput("MUL busy cycles", 32'(bc), 32'd33);
    checkOutput("MUL busy in DONE", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("MUL out_valid one cycle", 32'(out_valid), 32'd0);

    applyStimulus(3'b001, 32'h80000000, 32'h80000000, lat, bc, res);
    checkOutput("MULH result", res, 32'h40000000);
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, res);
    checkOutput("MULHU result", res, 32'hFFFFFFFE);
    applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, res);
    checkOutput("MULHSU result", res, 32'hFFFFFFFF);

    applyStimulus(3'b100, 32'hFFFFFFEC, 32'd3, lat, bc, res);
    checkOutput("DIV result", res, 32'hFFFFFFFA);
    checkOutput("DIV latency", 32'(lat), 32'd33);
    applyStimulus(3'b110, 32'hFFFFFFEC, 32'd3, lat, bc, res);
    checkOutput("REM result", res, 32'hFFFFFFFE);
    applyStimulus(3'b101, 32'd20, 32'd3, lat, bc, res);
    checkOutput("DIVU result", res, 32'd6);
    applyStimulus(3'b111, 32'd20, 32'd3, lat, bc, res);
    checkOutput("REMU result", res, 32'd2);

    applyStimulus(3'b100, 32'd5, 32'd0, lat, bc, res);
    checkOutput("DIV by zero result", res, 32'hFFFFFFFF);
    checkOutput("DIV by zero latency", 32'(lat), 32'd1);
    applyStimulus(3'b110, 32'd5, 32'd0, lat, bc, res);
    checkOutput("REM by zero result", res, 32'd5);
    checkOutput("REM by zero latency", 32'(lat), 32'd1);
    applyStimulus(3'b101, 32'd9, 32'd0, lat, bc, res);
    checkOutput("DIVU by zero result", res, 32'hFFFFFFFF);
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, bc, res);
    checkOutput("DIV overflow result", res, 32'h80000000);
    checkOutput("DIV overflow latency", 32'(lat), 32'd1);
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, lat, bc, res);
    checkOutput("REM overflow result", res, 32'h0);

    // Reset during the 10th CALC cycle; Result is nonzero beforehand from a prior op.
    applyStimulus(3'b101, 32'd20, 32'd3, lat, bc, res);
    startOp(3'b000, 32'd7, 32'd3, bc);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid-reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid-reset busy", 32'(busy), 32'd0);
    checkOutput("mid-reset Result", Result, 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("mid-reset no out_valid", 32'(seen), 32'd0);

    applyStimulus(3'b101, 32'd20, 32'd3, lat, bc, res);
    checkOutput("pre-flush DIVU result", res, 32'd6);
    startOp(3'b000, 32'd7, 32'd3, bc);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush Result kept", Result, 32'd6);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("flush no out_valid", 32'(seen), 32'd0);
    checkOutput("flush Result still kept", Result, 32'd6);

    in_valid = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b101;
    SrcA = 32'd50; SrcB = 32'd5; flush = 1'b1;
    #1 checkOutput("idle flush blocks busy", 32'(busy), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("idle flush in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle flush out_valid", 32'(out_valid), 32'd0);

    in_valid = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'b000;
    SrcA = 32'd3; SrcB = 32'd4;
    #1 checkOutput("non-M busy", 32'(busy), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("non-M in_ready", 32'(in_ready), 32'd1);
    checkOutput("non-M Result untouched", Result, 32'd6);

    // Back-to-back: in_valid held high with the second op queued behind the first.
    in_valid = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b011; SrcA = 32'hFFFFFFFF; SrcB = 32'd2;
    @(negedge clk);
    Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b first result", Result, 32'd1);
    checkOutput("b2b first latency", 32'(lat), 32'd33);
    checkOutput("b2b DONE in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b second accept in_ready", 32'(in_ready), 32'd1);
    checkOutput("b2b second accept busy", 32'(busy), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b second result", Result, 32'd14);
    checkOutput("b2b second latency", 32'(lat), 32'd33);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
